// File: rtl/constant_sequencer_pkg.sv
// Shared definitions for the constant sequencer family: state encoding
// and the index-width helper used by sibling sequencers.
`timescale 1ns/1ps
package constant_sequencer_pkg;

  localparam logic [0:0] IDLE_ENC = 1'b0;
  localparam logic [0:0] RUN_ENC  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = IDLE_ENC,
    ST_RUN  = RUN_ENC
  } state_t;

  // Width of an index that counts 0..count-1; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/constant_sequencer_if.sv
// Start and word stream bundle between the sequencer and its neighbours.
//
// Handshake rules for both streams (start_*, word_*): a transfer happens on a
// rising clock edge where valid and ready are both high. A producer holding
// valid high keeps its payload stable and does not drop valid until that
// transfer; a consumer may raise or lower ready at any time.
`timescale 1ns/1ps
interface constant_sequencer_if #(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned REPEAT_WIDTH = 4
) ();
  import constant_sequencer_pkg::*;

  logic                    start_valid;
  logic                    start_ready;
  logic [REPEAT_WIDTH-1:0] start_repeat;
  logic                    word_valid;
  logic                    word_ready;
  logic [WORD_WIDTH-1:0]   word_out;
  logic                    word_last;
  logic                    busy;
  logic                    done;
  state_t                  state_dbg;

  // Sequencer side: accepts starts, produces words and status.
  modport master (
    input  start_valid, start_repeat, word_ready,
    output start_ready, word_valid, word_out, word_last, busy, done, state_dbg
  );

  // Environment side: issues starts and consumes words.
  modport slave (
    output start_valid, start_repeat, word_ready,
    input  start_ready, word_valid, word_out, word_last, busy, done, state_dbg
  );

endinterface

// File: rtl/constant_sequencer_index_counter.sv
// Wrapping 0..WORD_COUNT-1 word index with load-zero and increment enable.
// Exposes the next index so the owner can register data selected by it.
`timescale 1ns/1ps
module constant_sequencer_index_counter
  import constant_sequencer_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 4,
  parameter int unsigned IDX_W      = idx_width(WORD_COUNT)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load_zero,
  input  logic             inc_en,
  output logic [IDX_W-1:0] index_next_o,
  output logic             wrap_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] index_d;

  // Next index: load-zero wins, otherwise step and wrap after the last word.
  always_comb begin
    index_d = index_q;
    if (load_zero) begin
      index_d = '0;
    end else if (inc_en) begin
      index_d = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
    end
  end

  // Index register.
  always_ff @(posedge clock) begin
    if (clear) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign index_next_o = index_d;
  assign wrap_o       = (index_q == LAST_IDX);

endmodule

// File: rtl/constant_sequencer.sv
// Streams a build-time table of constant words, start_repeat+1 times per run.
// Word outputs are registered from the next state/index so that a new word
// is presented on the cycle right after each handshake, with no bubbles.
`timescale 1ns/1ps
module constant_sequencer
  import constant_sequencer_pkg::*;
#(
  parameter int unsigned                     WORD_WIDTH   = 8,
  parameter int unsigned                     WORD_COUNT   = 4,
  parameter logic [WORD_WIDTH*WORD_COUNT-1:0] VALUES      = '0,
  parameter int unsigned                     REPEAT_WIDTH = 4
) (
  input logic                 clock,
  input logic                 clear,
  constant_sequencer_if.master bus
);

  localparam int unsigned      IDX_W    = idx_width(WORD_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  // Word 0 is the least-significant slice of VALUES.
  logic [WORD_WIDTH-1:0] table_w [WORD_COUNT];
  for (genvar g = 0; g < WORD_COUNT; g++) begin : g_table
    assign table_w[g] = VALUES[g*WORD_WIDTH +: WORD_WIDTH];
  end

  state_t                  state_q, state_d;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
  logic                    word_valid_q, word_valid_d;
  logic [WORD_WIDTH-1:0]   word_out_q, word_out_d;
  logic                    word_last_q, word_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    idx_load;
  logic                    idx_inc;
  logic [IDX_W-1:0]        idx_next;
  logic                    idx_wrap;

  constant_sequencer_index_counter #(
    .WORD_COUNT (WORD_COUNT),
    .IDX_W      (IDX_W)
  ) u_index (
    .clock        (clock),
    .clear        (clear),
    .load_zero    (idx_load),
    .inc_en       (idx_inc),
    .index_next_o (idx_next),
    .wrap_o       (idx_wrap)
  );

  // Control: start acceptance, word stepping, pass wrap and run completion,
  // then registered outputs derived from the resulting state and index.
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    idx_load = 1'b0;
    idx_inc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          state_d  = ST_RUN;
          pass_d   = bus.start_repeat;
          idx_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (word_valid_q && bus.word_ready) begin
          if (!idx_wrap) begin
            idx_inc = 1'b1;
          end else if (pass_q != '0) begin
            // End of an intermediate pass: rewind the table.
            idx_inc = 1'b1;
            pass_d  = pass_q - REPEAT_WIDTH'(1);
          end else begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            idx_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    word_valid_d = (state_d == ST_RUN);
    busy_d       = (state_d == ST_RUN);
    word_out_d   = (state_d == ST_RUN) ? table_w[idx_next] : '0;
    word_last_d  = (state_d == ST_RUN) && (idx_next == LAST_IDX) && (pass_d == '0);
  end

  // State, pass counter and registered outputs; clear overrides everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      pass_q       <= '0;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      word_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      word_valid_q <= word_valid_d;
      word_out_q   <= word_out_d;
      word_last_q  <= word_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.word_valid  = word_valid_q;
  assign bus.word_out    = word_out_q;
  assign bus.word_last   = word_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_constant_sequencer.sv
// Bench for constant_sequencer: a three-word table instance and a
// single-word table instance, checked against a queue-based run model.
`timescale 1ns/1ps
module tb_constant_sequencer;
  import constant_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  constant_sequencer_if #(.WORD_WIDTH(8), .REPEAT_WIDTH(2)) bus_a ();
  constant_sequencer_if #(.WORD_WIDTH(8), .REPEAT_WIDTH(2)) bus_b ();

  constant_sequencer #(
    .WORD_WIDTH(8), .WORD_COUNT(3), .VALUES(24'h332211), .REPEAT_WIDTH(2)
  ) dut_a (.clock(clock), .clear(clear), .bus(bus_a));

  constant_sequencer #(
    .WORD_WIDTH(8), .WORD_COUNT(1), .VALUES(8'hA5), .REPEAT_WIDTH(2)
  ) dut_b (.clock(clock), .clear(clear), .bus(bus_b));

  // ---------------- reference model ----------------
  logic [7:0] table_a [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] table_b [1] = '{8'hA5};
  logic [7:0] exp_q [$];

  // A run is the whole table, repeated rep+1 times, in table order.
  task automatic build_expected(input int which, input int rep);
    exp_q.delete();
    for (int p = 0; p <= rep; p++) begin
      if (which == 0) begin
        foreach (table_a[i]) exp_q.push_back(table_a[i]);
      end else begin
        foreach (table_b[i]) exp_q.push_back(table_b[i]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_a(input int rep);
    bus_a.start_repeat = 2'(rep);
    bus_a.start_valid  = 1'b1;
    tick();
    bus_a.start_valid  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b1;
    bus_a.start_valid = 1'b0; bus_a.start_repeat = '0; bus_a.word_ready = 1'b0;
    bus_b.start_valid = 1'b0; bus_b.start_repeat = '0; bus_b.word_ready = 1'b0;
    tick();
    tick();
    tests_run++; if (bus_a.start_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_start_ready got %b want 1", bus_a.start_ready); end
    tests_run++; if (bus_a.word_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_word_valid got %b want 0", bus_a.word_valid); end
    tests_run++; if (bus_a.word_out !== 8'h00) begin tests_failed++; $display("FAIL reset_word_out got %h want 00", bus_a.word_out); end
    tests_run++; if (bus_a.word_last !== 1'b0) begin tests_failed++; $display("FAIL reset_word_last got %b want 0", bus_a.word_last); end
    tests_run++; if (bus_a.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
    tests_run++; if (bus_a.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus_a.done); end
    tests_run++; if (bus_b.start_ready !== 1'b1 || bus_b.word_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_b got ready=%b valid=%b want 1/0", bus_b.start_ready, bus_b.word_valid); end
    clear = 1'b0;
    tick();
    tests_run++; if (bus_a.start_ready !== 1'b1 || bus_a.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset got ready=%b busy=%b want 1/0", bus_a.start_ready, bus_a.busy); end
  endtask

  task automatic test_single_pass();
    bus_a.word_ready = 1'b1;
    start_a(0);
    build_expected(0, 0);
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (bus_a.word_valid !== 1'b1 || bus_a.word_out !== exp_q[k]) begin tests_failed++; $display("FAIL single_word%0d got valid=%b word=%h want 1/%h", k, bus_a.word_valid, bus_a.word_out, exp_q[k]); end
      tests_run++; if (bus_a.word_last !== (k == 2)) begin tests_failed++; $display("FAIL single_last%0d got %b want %b", k, bus_a.word_last, (k == 2)); end
      tests_run++; if (bus_a.start_ready !== 1'b0 || bus_a.busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy%0d got ready=%b busy=%b want 0/1", k, bus_a.start_ready, bus_a.busy); end
      tick();
    end
    tests_run++; if (bus_a.done !== 1'b1 || bus_a.start_ready !== 1'b1) begin tests_failed++; $display("FAIL single_done got done=%b ready=%b want 1/1", bus_a.done, bus_a.start_ready); end
    tests_run++; if (bus_a.word_valid !== 1'b0 || bus_a.word_last !== 1'b0) begin tests_failed++; $display("FAIL single_idle got valid=%b last=%b want 0/0", bus_a.word_valid, bus_a.word_last); end
    tick();
    tests_run++; if (bus_a.done !== 1'b0) begin tests_failed++; $display("FAIL single_done_pulse got %b want 0", bus_a.done); end
  endtask

  task automatic test_toggle_ready();
    logic [7:0] held;
    bit         have_held;
    int         cyc;
    bus_a.word_ready = 1'b1;
    start_a(1);
    build_expected(0, 1);
    have_held = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      tests_run++; if (bus_a.word_valid !== 1'b1 || bus_a.word_out !== exp_q[0]) begin tests_failed++; $display("FAIL toggle_word c%0d got valid=%b word=%h want 1/%h", cyc, bus_a.word_valid, bus_a.word_out, exp_q[0]); end
      tests_run++; if (bus_a.word_last !== (exp_q.size() == 1)) begin tests_failed++; $display("FAIL toggle_last c%0d got %b want %b", cyc, bus_a.word_last, (exp_q.size() == 1)); end
      if (have_held) begin
        tests_run++; if (bus_a.word_out !== held) begin tests_failed++; $display("FAIL toggle_stall c%0d got %h want %h", cyc, bus_a.word_out, held); end
      end
      bus_a.word_ready = (cyc % 2 == 0);
      if (bus_a.word_ready) begin
        void'(exp_q.pop_front());
        have_held = 1'b0;
      end else begin
        held = bus_a.word_out;
        have_held = 1'b1;
      end
      tick();
      cyc++;
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL toggle_timeout got %0d words left want 0", exp_q.size()); end
    tests_run++; if (bus_a.done !== 1'b1) begin tests_failed++; $display("FAIL toggle_done got %b want 1", bus_a.done); end
    bus_a.word_ready = 1'b1;
    tick();
  endtask

  task automatic test_clear_mid_run();
    int done_seen;
    bus_a.word_ready = 1'b1;
    start_a(3);
    tick();
    tick();
    tests_run++; if (bus_a.word_out !== 8'h33) begin tests_failed++; $display("FAIL clear_pre_word got %h want 33", bus_a.word_out); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests_run++; if (bus_a.word_valid !== 1'b0 || bus_a.busy !== 1'b0) begin tests_failed++; $display("FAIL clear_idle got valid=%b busy=%b want 0/0", bus_a.word_valid, bus_a.busy); end
    tests_run++; if (bus_a.start_ready !== 1'b1 || bus_a.word_last !== 1'b0) begin tests_failed++; $display("FAIL clear_ready got ready=%b last=%b want 1/0", bus_a.start_ready, bus_a.word_last); end
    done_seen = (bus_a.done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_a.done === 1'b1 || bus_a.word_valid === 1'b1) done_seen++;
    end
    tests_run++; if (done_seen != 0) begin tests_failed++; $display("FAIL clear_no_done got %0d activity cycles want 0", done_seen); end
  endtask

  task automatic test_start_held();
    build_expected(0, 0);
    bus_a.word_ready   = 1'b1;
    bus_a.start_repeat = 2'd0;
    bus_a.start_valid  = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (bus_a.word_out !== exp_q[k] || bus_a.busy !== 1'b1 || bus_a.start_ready !== 1'b0) begin tests_failed++; $display("FAIL held_run1_w%0d got word=%h busy=%b ready=%b want %h/1/0", k, bus_a.word_out, bus_a.busy, bus_a.start_ready, exp_q[k]); end
      tick();
    end
    tests_run++; if (bus_a.done !== 1'b1 || bus_a.word_valid !== 1'b0 || bus_a.start_ready !== 1'b1) begin tests_failed++; $display("FAIL held_gap got done=%b valid=%b ready=%b want 1/0/1", bus_a.done, bus_a.word_valid, bus_a.start_ready); end
    tick();
    bus_a.start_valid = 1'b0;
    tests_run++; if (bus_a.word_valid !== 1'b1 || bus_a.word_out !== exp_q[0] || bus_a.done !== 1'b0) begin tests_failed++; $display("FAIL held_run2_start got valid=%b word=%h done=%b want 1/%h/0", bus_a.word_valid, bus_a.word_out, bus_a.done, exp_q[0]); end
    tick();
    tick();
    tick();
    tests_run++; if (bus_a.done !== 1'b1) begin tests_failed++; $display("FAIL held_run2_done got %b want 1", bus_a.done); end
    tick();
  endtask

  task automatic test_single_word();
    build_expected(1, 2);
    bus_b.word_ready   = 1'b1;
    bus_b.start_repeat = 2'd2;
    bus_b.start_valid  = 1'b1;
    tick();
    bus_b.start_valid  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (bus_b.word_valid !== 1'b1 || bus_b.word_out !== exp_q[k]) begin tests_failed++; $display("FAIL one_word%0d got valid=%b word=%h want 1/%h", k, bus_b.word_valid, bus_b.word_out, exp_q[k]); end
      tests_run++; if (bus_b.word_last !== (k == 2)) begin tests_failed++; $display("FAIL one_last%0d got %b want %b", k, bus_b.word_last, (k == 2)); end
      tick();
    end
    tests_run++; if (bus_b.done !== 1'b1 || bus_b.word_valid !== 1'b0) begin tests_failed++; $display("FAIL one_done got done=%b valid=%b want 1/0", bus_b.done, bus_b.word_valid); end
    tick();
  endtask

  task automatic test_random_runs();
    int rep;
    int cyc;
    int n_words;
    for (int r = 0; r < 8; r++) begin
      rep = (r == 0) ? 3 : int'($urandom_range(0, 3));
      build_expected(0, rep);
      n_words = exp_q.size();
      repeat ($urandom_range(0, 3)) tick();
      tests_run++; if (bus_a.start_ready !== 1'b1) begin tests_failed++; $display("FAIL rand_ready r%0d got %b want 1", r, bus_a.start_ready); end
      bus_a.word_ready = 1'b1;
      start_a(rep);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
        tests_run++; if (bus_a.word_valid !== 1'b1 || bus_a.word_out !== exp_q[0] || bus_a.word_last !== (exp_q.size() == 1)) begin tests_failed++; $display("FAIL rand_word r%0d c%0d got valid=%b word=%h last=%b want 1/%h/%b", r, cyc, bus_a.word_valid, bus_a.word_out, bus_a.word_last, exp_q[0], (exp_q.size() == 1)); end
        bus_a.word_ready  = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus_a.start_valid = 1'($urandom_range(0, 1));
        if (bus_a.word_ready) void'(exp_q.pop_front());
        tick();
        cyc++;
      end
      bus_a.start_valid = 1'b0;
      tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_timeout r%0d got %0d words left want 0", r, exp_q.size()); end
      if (r == 0) begin
        tests_run++; if (cyc != n_words) begin tests_failed++; $display("FAIL rand_no_bubble got %0d cycles want %0d", cyc, n_words); end
      end
      tests_run++; if (bus_a.done !== 1'b1 || bus_a.word_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_done r%0d got done=%b valid=%b want 1/0", r, bus_a.done, bus_a.word_valid); end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_pass();
    test_toggle_ready();
    test_clear_mid_run();
    test_start_held();
    test_single_word();
    test_random_runs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
